// File: rtl/stm_silencer.sv
// Per-transducer intensity/phase slew limiter for the STM output stream, 2-cycle pipeline.
// Define STM_SILENCER_DEBUG_EN to add the DEBUG_IDX / DEBUG_SETTLING observation ports.
module stm_silencer #(
  parameter int DEPTH = 249
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic                     DIN_VALID,
  input  logic [7:0]               INTENSITY_IN,
  input  logic [7:0]               PHASE_IN,
  input  logic [7:0]               STEP_INTENSITY,
  input  logic [7:0]               STEP_PHASE,
  output logic [7:0]               INTENSITY,
  output logic [7:0]               PHASE,
`ifdef STM_SILENCER_DEBUG_EN
  output logic [$clog2(DEPTH)-1:0] DEBUG_IDX,
  output logic                     DEBUG_SETTLING,
`endif
  output logic                     DOUT_VALID
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  function automatic logic [7:0] limit_intensity(input logic [7:0] cur, input logic [7:0] tgt,
                                                 input logic [7:0] step);
    logic [7:0] diff;
    diff = (tgt > cur) ? (tgt - cur) : (cur - tgt);
    if ((step == 8'd0) || (diff <= step)) begin
      limit_intensity = tgt;
    end else if (tgt > cur) begin
      limit_intensity = cur + step;
    end else begin
      limit_intensity = cur - step;
    end
  endfunction

  // Shortest-path limiter on the phase circle; a half-turn difference moves upward.
  function automatic logic [7:0] limit_phase(input logic [7:0] cur, input logic [7:0] tgt,
                                             input logic [7:0] step);
    logic [7:0] d;
    logic [7:0] mag;
    d   = tgt - cur;
    mag = d[7] ? (8'd0 - d) : d;
    if ((step == 8'd0) || (mag <= step)) begin
      limit_phase = tgt;
    end else if (d[7] && (d != 8'h80)) begin
      limit_phase = cur - step;
    end else begin
      limit_phase = cur + step;
    end
  endfunction

  logic [15:0]   state_mem [DEPTH];
  logic [IW-1:0] idx_r;
  logic [7:0]    step_i_r;
  logic [7:0]    step_p_r;

  logic          s1_valid_r;
  logic [IW-1:0] s1_idx_r;
  logic [7:0]    s1_tgt_i_r;
  logic [7:0]    s1_tgt_p_r;
  logic [7:0]    s1_step_i_r;
  logic [7:0]    s1_step_p_r;
  logic [7:0]    s1_cur_i_r;
  logic [7:0]    s1_cur_p_r;

  logic [IW-1:0] idx_sel_s;
  logic [7:0]    step_i_sel_s;
  logic [7:0]    step_p_sel_s;
  logic [15:0]   cur_s;
  logic [7:0]    new_i_s;
  logic [7:0]    new_p_s;

  // Element index, frame step selection and forwarding of an in-flight write to the same element.
  always_comb begin
    idx_sel_s    = START ? {IW{1'b0}} : idx_r;
    step_i_sel_s = step_i_r;
    step_p_sel_s = step_p_r;
    if (idx_sel_s == {IW{1'b0}}) begin
      step_i_sel_s = STEP_INTENSITY;
      step_p_sel_s = STEP_PHASE;
    end else begin
      step_i_sel_s = step_i_r;
      step_p_sel_s = step_p_r;
    end
    new_i_s = limit_intensity(s1_cur_i_r, s1_tgt_i_r, s1_step_i_r);
    new_p_s = limit_phase(s1_cur_p_r, s1_tgt_p_r, s1_step_p_r);
    cur_s   = state_mem[idx_sel_s];
    if (s1_valid_r && (s1_idx_r == idx_sel_s)) begin
      cur_s = {new_i_s, new_p_s};
    end else begin
      cur_s = state_mem[idx_sel_s];
    end
  end

  // Index counter and per-frame step latch captured on element 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_r    <= {IW{1'b0}};
      step_i_r <= 8'd0;
      step_p_r <= 8'd0;
    end else if (DIN_VALID) begin
      idx_r <= (idx_sel_s == LAST_IDX) ? {IW{1'b0}} : (idx_sel_s + IW'(1));
      if (idx_sel_s == {IW{1'b0}}) begin
        step_i_r <= STEP_INTENSITY;
        step_p_r <= STEP_PHASE;
      end
    end else if (START) begin
      idx_r <= {IW{1'b0}};
    end
  end

  // Stage 1: capture target, index, steps and current state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_r  <= 1'b0;
      s1_idx_r    <= {IW{1'b0}};
      s1_tgt_i_r  <= 8'd0;
      s1_tgt_p_r  <= 8'd0;
      s1_step_i_r <= 8'd0;
      s1_step_p_r <= 8'd0;
      s1_cur_i_r  <= 8'd0;
      s1_cur_p_r  <= 8'd0;
    end else begin
      s1_valid_r <= DIN_VALID;
      if (DIN_VALID) begin
        s1_idx_r    <= idx_sel_s;
        s1_tgt_i_r  <= INTENSITY_IN;
        s1_tgt_p_r  <= PHASE_IN;
        s1_step_i_r <= step_i_sel_s;
        s1_step_p_r <= step_p_sel_s;
        s1_cur_i_r  <= cur_s[15:8];
        s1_cur_p_r  <= cur_s[7:0];
      end
    end
  end

  // Stage 2: register outputs and write the emitted value back as the element's new state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DOUT_VALID <= 1'b0;
      INTENSITY  <= 8'd0;
      PHASE      <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        state_mem[i] <= 16'd0;
      end
    end else begin
      DOUT_VALID <= s1_valid_r;
      if (s1_valid_r) begin
        INTENSITY           <= new_i_s;
        PHASE               <= new_p_s;
        state_mem[s1_idx_r] <= {new_i_s, new_p_s};
      end
    end
  end

`ifdef STM_SILENCER_DEBUG_EN
  logic settle_acc_r;
  logic differs_s;

  assign differs_s = (new_i_s != s1_tgt_i_r) || (new_p_s != s1_tgt_p_r);

  // Debug: output index and per-frame "still settling" flag published at the last element.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DEBUG_IDX      <= {IW{1'b0}};
      DEBUG_SETTLING <= 1'b0;
      settle_acc_r   <= 1'b0;
    end else if (s1_valid_r) begin
      DEBUG_IDX <= s1_idx_r;
      if (s1_idx_r == LAST_IDX) begin
        DEBUG_SETTLING <= settle_acc_r | differs_s;
        settle_acc_r   <= 1'b0;
      end else begin
        settle_acc_r <= settle_acc_r | differs_s;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stm_silencer.sv
// Directed bench for stm_silencer: table of uniform frames plus hand-written corner sequences.
module tb_stm_silencer;

  localparam int DEPTH = 249;
  localparam int IW    = $clog2(DEPTH);

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       DIN_VALID;
  logic [7:0] INTENSITY_IN;
  logic [7:0] PHASE_IN;
  logic [7:0] STEP_INTENSITY;
  logic [7:0] STEP_PHASE;
  logic [7:0] INTENSITY;
  logic [7:0] PHASE;
  logic       DOUT_VALID;
`ifdef STM_SILENCER_DEBUG_EN
  logic [IW-1:0] DEBUG_IDX;
  logic          DEBUG_SETTLING;
`endif

  stm_silencer #(.DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .START         (START),
    .DIN_VALID     (DIN_VALID),
    .INTENSITY_IN  (INTENSITY_IN),
    .PHASE_IN      (PHASE_IN),
    .STEP_INTENSITY(STEP_INTENSITY),
    .STEP_PHASE    (STEP_PHASE),
    .INTENSITY     (INTENSITY),
    .PHASE         (PHASE),
`ifdef STM_SILENCER_DEBUG_EN
    .DEBUG_IDX     (DEBUG_IDX),
    .DEBUG_SETTLING(DEBUG_SETTLING),
`endif
    .DOUT_VALID    (DOUT_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] ti, tp, si, sp, ei, ep;
    bit         use_start;
  } vec_t;

  typedef struct {
    logic [7:0] ei, ep;
    int         cyc;
  } exp_t;

  vec_t vecs[27];
  exp_t expq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: every output must match its queued expectation exactly two cycles after input.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && DOUT_VALID) begin
      n_checks++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_dout_valid: got INTENSITY=%0d PHASE=%0d, required no output", INTENSITY, PHASE);
      end else begin
        e = expq.pop_front();
        if (INTENSITY !== e.ei || PHASE !== e.ep || cyc !== e.cyc + 2) begin
          n_fail++;
          $display("FAIL output: got %0d/%0d at cycle %0d, required %0d/%0d at cycle %0d",
                   INTENSITY, PHASE, cyc, e.ei, e.ep, e.cyc + 2);
        end
      end
    end
  end

  task automatic send(input bit st, input logic [7:0] ti, input logic [7:0] tp, input logic [7:0] si,
                      input logic [7:0] sp, input logic [7:0] ei, input logic [7:0] ep);
    @(posedge CLK); #1;
    START          = st;
    DIN_VALID      = 1'b1;
    INTENSITY_IN   = ti;
    PHASE_IN       = tp;
    STEP_INTENSITY = si;
    STEP_PHASE     = sp;
    expq.push_back('{ei, ep, cyc});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      START     = 1'b0;
      DIN_VALID = 1'b0;
    end
  endtask

  task automatic check(input string name, input int got, input int req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    // {ti, tp, si, sp, ei, ep, use_start}
    vecs[0]  = '{8'd200, 8'd100, 8'd0,  8'd0,  8'd200, 8'd100, 1'b0};
    vecs[1]  = '{8'd0,   8'd0,   8'd0,  8'd0,  8'd0,   8'd0,   1'b1};
    vecs[2]  = '{8'd200, 8'd100, 8'd16, 8'd16, 8'd16,  8'd16,  1'b1};
    vecs[3]  = '{8'd200, 8'd100, 8'd16, 8'd16, 8'd32,  8'd32,  1'b1};
    vecs[4]  = '{8'd200, 8'd100, 8'd16, 8'd16, 8'd48,  8'd48,  1'b1};
    vecs[5]  = '{8'd200, 8'd100, 8'd16, 8'd16, 8'd64,  8'd64,  1'b1};
    vecs[6]  = '{8'd200, 8'd100, 8'd16, 8'd16, 8'd80,  8'd80,  1'b1};
    vecs[7]  = '{8'd200, 8'd100, 8'd16, 8'd16, 8'd96,  8'd96,  1'b1};
    vecs[8]  = '{8'd200, 8'd100, 8'd16, 8'd16, 8'd112, 8'd100, 1'b1};
    vecs[9]  = '{8'd200, 8'd100, 8'd16, 8'd16, 8'd128, 8'd100, 1'b1};
    vecs[10] = '{8'd200, 8'd100, 8'd16, 8'd16, 8'd144, 8'd100, 1'b1};
    vecs[11] = '{8'd200, 8'd100, 8'd16, 8'd16, 8'd160, 8'd100, 1'b1};
    vecs[12] = '{8'd200, 8'd100, 8'd16, 8'd16, 8'd176, 8'd100, 1'b1};
    vecs[13] = '{8'd200, 8'd100, 8'd16, 8'd16, 8'd192, 8'd100, 1'b1};
    vecs[14] = '{8'd200, 8'd100, 8'd16, 8'd16, 8'd200, 8'd100, 1'b1};
    vecs[15] = '{8'd200, 8'd100, 8'd16, 8'd16, 8'd200, 8'd100, 1'b1};
    vecs[16] = '{8'd0,   8'd250, 8'd0,  8'd0,  8'd0,   8'd250, 1'b1};
    vecs[17] = '{8'd0,   8'd4,   8'd0,  8'd3,  8'd0,   8'd253, 1'b1};
    vecs[18] = '{8'd0,   8'd4,   8'd0,  8'd3,  8'd0,   8'd0,   1'b1};
    vecs[19] = '{8'd0,   8'd4,   8'd0,  8'd3,  8'd0,   8'd3,   1'b1};
    vecs[20] = '{8'd0,   8'd4,   8'd0,  8'd3,  8'd0,   8'd4,   1'b1};
    vecs[21] = '{8'd0,   8'd0,   8'd0,  8'd0,  8'd0,   8'd0,   1'b1};
    vecs[22] = '{8'd0,   8'd128, 8'd0,  8'd10, 8'd0,   8'd10,  1'b1};
    vecs[23] = '{8'd30,  8'd5,   8'd0,  8'd3,  8'd30,  8'd7,   1'b1};
    vecs[24] = '{8'd10,  8'd5,   8'd8,  8'd3,  8'd22,  8'd5,   1'b1};
    vecs[25] = '{8'd10,  8'd5,   8'd8,  8'd3,  8'd14,  8'd5,   1'b1};
    vecs[26] = '{8'd10,  8'd5,   8'd8,  8'd3,  8'd10,  8'd5,   1'b1};

    RST = 1'b1; START = 1'b0; DIN_VALID = 1'b0;
    INTENSITY_IN = 8'd0; PHASE_IN = 8'd0; STEP_INTENSITY = 8'd0; STEP_PHASE = 8'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_dout_valid", DOUT_VALID, 0);
    check("reset_intensity", INTENSITY, 0);
    check("reset_phase", PHASE, 0);
    RST = 1'b0;

    for (int v = 0; v < 27; v++) begin
      for (int i = 0; i < DEPTH; i++) begin
        send(vecs[v].use_start && (i == 0), vecs[v].ti, vecs[v].tp, vecs[v].si, vecs[v].sp,
             vecs[v].ei, vecs[v].ep);
      end
    end

    // Mid-frame step change: state 10, step 8 for the whole frame, 64 from the next frame.
    for (int i = 0; i < DEPTH; i++) send(i == 0, 8'd200, 8'd5, (i < 100) ? 8'd8 : 8'd64, 8'd0, 8'd18, 8'd5);
    for (int i = 0; i < DEPTH; i++) send(i == 0, 8'd200, 8'd5, 8'd64, 8'd0, 8'd82, 8'd5);

    // START at element 50 restarts at idx 0; elements 50.. keep their old state.
    for (int i = 0; i < 50; i++) send(i == 0, 8'd0, 8'd5, 8'd0, 8'd0, 8'd0, 8'd5);
    for (int j = 0; j < 3; j++) send(j == 0, 8'd33, 8'd5, 8'd0, 8'd0, 8'd33, 8'd5);
    for (int i = 0; i < DEPTH; i++) begin
      send(i == 0, 8'd255, 8'd5, 8'd1, 8'd0, (i < 3) ? 8'd34 : ((i < 50) ? 8'd1 : 8'd83), 8'd5);
    end
    idle(4);
    check("drain_after_start_test", expq.size(), 0);

    // Reset during a burst clears outputs at once and wipes all state.
    for (int i = 0; i < 20; i++) send(i == 0, 8'd0, 8'd5, 8'd0, 8'd0, 8'd0, 8'd5);
    @(posedge CLK); #1;
    RST = 1'b1; DIN_VALID = 1'b0; START = 1'b0;
    expq.delete();
    #1;
    check("rst_dout_valid", DOUT_VALID, 0);
    check("rst_intensity", INTENSITY, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // No START after reset: counting from idx 0 latches step 4; gaps must propagate.
    for (int i = 0; i < DEPTH; i++) begin
      send(1'b0, 8'd40, 8'd40, 8'd4, 8'd4, 8'd4, 8'd4);
      if (i % 7 == 3) idle(1 + (i % 3));
    end
    idle(5);
    check("drain_final", expq.size(), 0);
    check("idle_dout_valid", DOUT_VALID, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
